spi_reg_ctrl: RTL and testbench

Register-access controller that sequences the FPGA's SPI slave byte interface into a simple addressed register bus. It turns each SPI transaction into one command byte followed by a burst of data bytes. The command byte carries a read/write flag and a 7-bit start address, and the address auto-increments for burst access. It sits between the SPI slave and the FPGA control registers (firmware version, bootloader-force pin, UART inversion and telemetry select), so those registers can be served from one decoder.

---
 rtl/spi_reg_ctrl.sv | 171 +++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI byte-stream to register-bus sequencer: a command byte (rw flag + start address)
// followed by an auto-incrementing burst of register reads or writes.
module spi_reg_ctrl #(
    parameter int          ADDR_W     = 7,
    parameter logic [7:0]  FW_VERSION = 8'hC2
) (
    input  logic              clk_core,
    input  logic              reset,
    input  logic              transaction_begin,
    input  logic              rx_byte_available,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic [7:0]        byte_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_RFETCH = 3'd2,
        S_RWAIT  = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5
    } state_t;

    state_t            state_q;
    logic [1:0]        hist_q;
    logic [ADDR_W-1:0] addr_q;
    logic [11:0]       tout_q;
    logic [7:0]        tx_byte_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_wr_q;
    logic              reg_rd_q;
    logic              busy_q;
    logic [7:0]        byte_count_q;

    logic              evt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic [7:0]        count_d;

    // Byte event, next burst address and saturating byte count
    always_comb begin
        evt_d      = (hist_q == 2'b01);
        addr_d     = addr_q + ADDR_W'(1'b1);
        cmd_addr_d = ADDR_W'(rx_byte[6:0]);
        if (byte_count_q == 8'hFF) begin
            count_d = 8'hFF;
        end else begin
            count_d = byte_count_q + 8'd1;
        end
    end

    // Transaction FSM; strobes default low so each lasts exactly one cycle
    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hist_q       <= 2'b00;
            addr_q       <= '0;
            tout_q       <= 12'd0;
            tx_byte_q    <= 8'h00;
            reg_addr_q   <= '0;
            reg_wdata_q  <= 8'h00;
            reg_wr_q     <= 1'b0;
            reg_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            byte_count_q <= 8'h00;
        end else begin
            hist_q   <= {hist_q[0], rx_byte_available};
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;
            if (transaction_begin) begin
                state_q      <= S_CMD;
                tx_byte_q    <= 8'h00;
                byte_count_q <= 8'h00;
                busy_q       <= 1'b1;
                tout_q       <= 12'd0;
            end else if ((state_q != S_IDLE) && !evt_d && (tout_q == 12'hFFF)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                tout_q  <= 12'd0;
            end else begin
                if ((state_q == S_IDLE) || evt_d) begin
                    tout_q <= 12'd0;
                end else begin
                    tout_q <= tout_q + 12'd1;
                end
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_CMD: begin
                        if (evt_d) begin
                            addr_q <= cmd_addr_d;
                            if (rx_byte[7]) begin
                                state_q <= S_WDATA;
                            end else if (cmd_addr_d == '0) begin
                                tx_byte_q <= FW_VERSION;
                                state_q   <= S_RDATA;
                            end else begin
                                reg_rd_q   <= 1'b1;
                                reg_addr_q <= cmd_addr_d;
                                state_q    <= S_RFETCH;
                            end
                        end else begin
                            state_q <= S_CMD;
                        end
                    end
                    S_RFETCH: begin
                        state_q <= S_RWAIT;
                    end
                    S_RWAIT: begin
                        tx_byte_q <= reg_rdata;
                        state_q   <= S_RDATA;
                    end
                    S_RDATA: begin
                        if (evt_d) begin
                            addr_q       <= addr_d;
                            byte_count_q <= count_d;
                            // Address 0 is served locally, never fetched from the bus
                            if (addr_d == '0) begin
                                tx_byte_q <= FW_VERSION;
                                state_q   <= S_RDATA;
                            end else begin
                                reg_rd_q   <= 1'b1;
                                reg_addr_q <= addr_d;
                                state_q    <= S_RFETCH;
                            end
                        end else begin
                            state_q <= S_RDATA;
                        end
                    end
                    S_WDATA: begin
                        if (evt_d) begin
                            addr_q       <= addr_d;
                            byte_count_q <= count_d;
                            if (addr_q != '0) begin
                                reg_wr_q    <= 1'b1;
                                reg_addr_q  <= addr_q;
                                reg_wdata_q <= rx_byte;
                            end else begin
                                reg_wr_q <= 1'b0;
                            end
                        end else begin
                            state_q <= S_WDATA;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_byte    = tx_byte_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_wr     = reg_wr_q;
    assign reg_rd     = reg_rd_q;
    assign busy       = busy_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: a vector table of SPI bytes with hand-computed bus
// activity, plus sequences for reset, idle-state events, reset mid-read and the idle timeout.
module tb_spi_reg_ctrl;

    logic       clk_core = 1'b0;
    logic       reset;
    logic       transaction_begin;
    logic       rx_byte_available;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    logic [7:0] byte_count;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int both_high = 0;

    spi_reg_ctrl dut (
        .clk_core          (clk_core),
        .reset             (reset),
        .transaction_begin (transaction_begin),
        .rx_byte_available (rx_byte_available),
        .rx_byte           (rx_byte),
        .tx_byte           (tx_byte),
        .reg_addr          (reg_addr),
        .reg_wdata         (reg_wdata),
        .reg_wr            (reg_wr),
        .reg_rd            (reg_rd),
        .reg_rdata         (reg_rdata),
        .busy              (busy),
        .byte_count        (byte_count)
    );

    always #5 clk_core = ~clk_core;

    always @(negedge clk_core) begin
        if (reg_wr) wr_pulses++;
        if (reg_rd) rd_pulses++;
        if (reg_wr && reg_rd) both_high++;
    end

    typedef struct {
        logic       beg;
        logic [7:0] data;
        logic [7:0] rdata;
        logic       exp_wr;
        logic       exp_rd;
        logic [6:0] exp_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_cnt;
        logic [7:0] exp_tx1;
        logic [7:0] exp_tx3;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx"},    32'(tx_byte),    32'h0);
        check({tag, "_addr"},  32'(reg_addr),   32'h0);
        check({tag, "_wdata"}, 32'(reg_wdata),  32'h0);
        check({tag, "_wr"},    32'(reg_wr),     32'h0);
        check({tag, "_rd"},    32'(reg_rd),     32'h0);
        check({tag, "_busy"},  32'(busy),       32'h0);
        check({tag, "_cnt"},   32'(byte_count), 32'h0);
    endtask

    initial begin
        int wr0;
        int rd0;
        // beg data rdata wr rd addr wdata cnt tx@E+1 tx@E+3
        vecs[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 8'd0, 8'hC2, 8'hC2};
        vecs[1]  = '{1'b1, 8'h81, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00, 8'd0, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 7'h01, 8'h01, 8'd1, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 7'h02, 8'h05, 8'd2, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'h7F, 8'h5A, 1'b0, 1'b1, 7'h7F, 8'h05, 8'd0, 8'h00, 8'h5A};
        vecs[5]  = '{1'b0, 8'hFF, 8'h5A, 1'b0, 1'b0, 7'h7F, 8'h05, 8'd1, 8'hC2, 8'hC2};
        vecs[6]  = '{1'b0, 8'h00, 8'h33, 1'b0, 1'b1, 7'h01, 8'h05, 8'd2, 8'hC2, 8'h33};
        vecs[7]  = '{1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 7'h01, 8'h05, 8'd0, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 8'hAA, 8'h00, 1'b0, 1'b0, 7'h01, 8'h05, 8'd1, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 7'h01, 8'h10, 8'd2, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 8'h85, 8'h00, 1'b0, 1'b0, 7'h01, 8'h10, 8'd0, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 7'h05, 8'h77, 8'd1, 8'h00, 8'h00};
        vecs[12] = '{1'b1, 8'h02, 8'h9C, 1'b0, 1'b1, 7'h02, 8'h77, 8'd0, 8'h00, 8'h9C};

        reset             = 1'b1;
        transaction_begin = 1'b0;
        rx_byte_available = 1'b0;
        rx_byte           = 8'h00;
        reg_rdata         = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_values("rst");

        // Byte events without a transaction are ignored
        wr0 = wr_pulses;
        rx_byte = 8'h81;
        rx_byte_available = 1'b1;
        repeat (4) tick();
        check("idle_busy", 32'(busy), 32'h0);
        rx_byte = 8'h01;
        rx_byte_available = 1'b0;
        repeat (3) tick();
        check("idle_no_wr", 32'(wr_pulses - wr0), 32'h0);

        for (int i = 0; i < 13; i++) begin
            reg_rdata = vecs[i].rdata;
            wr0 = wr_pulses;
            rd0 = rd_pulses;
            if (vecs[i].beg) begin
                transaction_begin = 1'b1;
                tick();
                transaction_begin = 1'b0;
                check($sformatf("v%0d_beg_busy", i), 32'(busy), 32'h1);
                check($sformatf("v%0d_beg_cnt", i), 32'(byte_count), 32'h0);
            end
            rx_byte = vecs[i].data;
            rx_byte_available = 1'b1;
            tick();
            tick();
            check($sformatf("v%0d_wr", i),    32'(reg_wr),     32'(vecs[i].exp_wr));
            check($sformatf("v%0d_rd", i),    32'(reg_rd),     32'(vecs[i].exp_rd));
            check($sformatf("v%0d_addr", i),  32'(reg_addr),   32'(vecs[i].exp_addr));
            check($sformatf("v%0d_wdata", i), 32'(reg_wdata),  32'(vecs[i].exp_wdata));
            check($sformatf("v%0d_cnt", i),   32'(byte_count), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_tx1", i),   32'(tx_byte),    32'(vecs[i].exp_tx1));
            tick();
            tick();
            check($sformatf("v%0d_tx3", i),   32'(tx_byte),    32'(vecs[i].exp_tx3));
            check($sformatf("v%0d_busy", i),  32'(busy),       32'h1);
            rx_byte_available = 1'b0;
            repeat (3) tick();
            check($sformatf("v%0d_nwr", i), 32'(wr_pulses - wr0), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_nrd", i), 32'(rd_pulses - rd0), 32'(vecs[i].exp_rd));
        end

        // Reset sampled on the edge that would launch the read fetch
        rd0 = rd_pulses;
        transaction_begin = 1'b1;
        tick();
        transaction_begin = 1'b0;
        rx_byte = 8'h03;
        rx_byte_available = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        tick();
        check("midrst_rd_after", 32'(reg_rd), 32'h0);
        check("midrst_busy_after", 32'(busy), 32'h0);
        rx_byte_available = 1'b0;
        repeat (3) tick();
        check("midrst_no_rd", 32'(rd_pulses - rd0), 32'h0);

        // Idle timeout returns to IDLE after 4096 quiet cycles
        transaction_begin = 1'b1;
        tick();
        transaction_begin = 1'b0;
        repeat (4090) tick();
        check("tout_still_busy", 32'(busy), 32'h1);
        repeat (10) tick();
        check("tout_idle", 32'(busy), 32'h0);

        check("rd_wr_exclusive", 32'(both_high), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
